// File: rtl/key_pkg.sv
// Shared types and constants for the push-button debouncer.
// Optional long-press detection is enabled with macro KEY_DEBOUNCE_LONG_PRESS_EN.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_t;

  // Button is active-low: a released key reads 1.
  localparam logic KEY_RELEASED = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit with a configurable reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises the raw active-low key, qualifies each level
// change over CNT_MAX cycles, and reports a clean level, a change strobe and a
// press counter. Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press detector;
// otherwise long_flag is tied low.
module key_debounce
  import key_pkg::*;
#(
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key,
  output logic       key_value,
  output logic       key_flag,
  output logic [7:0] press_cnt,
  output logic       long_flag
);

  localparam int CNT_W = $clog2(LONG_MAX + 1);

  // The cycle in which the FSM first sees the new level counts as the first of the
  // CNT_MAX qualify cycles, so the CHK state commits after CNT_MAX-1 further cycles.
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(CNT_MAX - 2);

  logic             w_key_sync;
  key_state_t       r_state;
  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_value;
  logic             w_value_nxt;
  logic             r_key_flag;
  logic             w_flag_nxt;
  logic [7:0]       r_press_cnt;
  logic             w_press_inc;

  sync_2ff #(
    .RST_VAL (KEY_RELEASED)
  ) u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (key),
    .o_q     (w_key_sync)
  );

  // State, qualify counter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_key_value <= KEY_RELEASED;
      r_key_flag  <= 1'b0;
      r_press_cnt <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_value <= w_value_nxt;
      r_key_flag  <= w_flag_nxt;
      if (w_press_inc) begin
        r_press_cnt <= r_press_cnt + 8'd1;
      end
    end
  end

  // Next-state logic: every state change clears the qualify counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_value_nxt = r_key_value;
    w_flag_nxt  = 1'b0;
    w_press_inc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_key_sync == KEY_PRESSED) begin
          w_state_nxt = PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (w_key_sync == KEY_RELEASED) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == QUAL_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_value_nxt = KEY_PRESSED;
          w_flag_nxt  = 1'b1;
          w_press_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (w_key_sync == KEY_RELEASED) begin
          w_state_nxt = RELEASE_CHK;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (w_key_sync == KEY_PRESSED) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == QUAL_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_value_nxt = KEY_RELEASED;
          w_flag_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_value = r_key_value;
  assign key_flag  = r_key_flag;
  assign press_cnt = r_press_cnt;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MAX - 1);
  localparam logic [CNT_W-1:0] LONG_TOP  = CNT_W'(LONG_MAX);

  logic [CNT_W-1:0] r_hold;
  logic             r_long_flag;

  // Hold counter: runs only in HELD, parks at LONG_MAX after firing so exactly one
  // pulse is produced per press; release bounces keep the count, IDLE entry clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold      <= '0;
      r_long_flag <= 1'b0;
    end else begin
      r_long_flag <= 1'b0;
      if (w_state_nxt == IDLE) begin
        r_hold <= '0;
      end else if (r_state == HELD) begin
        if (r_hold != LONG_TOP) begin
          r_hold <= r_hold + 1'b1;
        end
        if (r_hold == LONG_LAST) begin
          r_long_flag <= 1'b1;
        end
      end
    end
  end

  assign long_flag = r_long_flag;
`else
  assign long_flag = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed testbench for key_debounce with CNT_MAX=5, LONG_MAX=20.
`timescale 1ns/1ps
module tb_key_debounce;
  import key_pkg::*;

  localparam int CNT_MAX  = 5;
  localparam int LONG_MAX = 20;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key;
  logic       key_value;
  logic       key_flag;
  logic [7:0] press_cnt;
  logic       long_flag;

  int n_cmp;
  int n_fail;
  int n_flag;
  int n_long;
  int flag_base;
  int long_base;

  key_debounce #(
    .CNT_MAX  (CNT_MAX),
    .LONG_MAX (LONG_MAX)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .key_value (key_value),
    .key_flag  (key_flag),
    .press_cnt (press_cnt),
    .long_flag (long_flag)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance n rising edges, sampling 1 ns after each edge and tallying pulses.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
      if (key_flag === 1'b1) n_flag++;
      if (long_flag === 1'b1) n_long++;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full qualified press and release from IDLE.
  task automatic do_press();
    key = 1'b0;
    tick(7);
    key = 1'b1;
    tick(7);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    n_flag = 0;
    n_long = 0;

    // 1: reset with key held low
    sys_rst_n = 1'b0;
    key       = 1'b0;
    tick(1);
    check("rst_value", int'(key_value), 1);
    check("rst_flag", int'(key_flag), 0);
    check("rst_cnt", int'(press_cnt), 0);
    tick(2);
    check("rst_value_hold", int'(key_value), 1);
    check("rst_cnt_hold", int'(press_cnt), 0);
    check("rst_long", int'(long_flag), 0);
    key       = 1'b1;
    sys_rst_n = 1'b1;
    tick(3);
    check("rst_exit_value", int'(key_value), 1);
    check("rst_exit_flags", n_flag, 0);

    // 2: clean press then clean release
    key = 1'b0;
    tick(6);
    check("press_early_value", int'(key_value), 1);
    check("press_early_flag", n_flag, 0);
    tick(1);
    check("press_value", int'(key_value), 0);
    check("press_flag", int'(key_flag), 1);
    check("press_cnt1", int'(press_cnt), 1);
    tick(1);
    check("press_flag_end", int'(key_flag), 0);
    tick(12);
    check("held_value", int'(key_value), 0);
    check("held_flags", n_flag, 1);
    key = 1'b1;
    tick(6);
    check("rel_early_value", int'(key_value), 0);
    tick(1);
    check("rel_value", int'(key_value), 1);
    check("rel_flag", int'(key_flag), 1);
    check("rel_cnt", int'(press_cnt), 1);
    tick(1);
    check("rel_flag_end", int'(key_flag), 0);
    tick(3);

    // 3: bounce before a stable press
    flag_base = n_flag;
    key = 1'b0; tick(2);
    key = 1'b1; tick(2);
    key = 1'b0; tick(2);
    key = 1'b1; tick(3);
    check("bounce_value", int'(key_value), 1);
    key = 1'b0;
    tick(6);
    check("bounce_no_flag", n_flag - flag_base, 0);
    check("bounce_early_value", int'(key_value), 1);
    tick(1);
    check("bounce_value_low", int'(key_value), 0);
    check("bounce_flag", int'(key_flag), 1);
    check("bounce_cnt", int'(press_cnt), 2);
    key = 1'b1;
    tick(8);
    check("bounce_released", int'(key_value), 1);

    // 4: press counter wrap
    sys_rst_n = 1'b0;
    tick(1);
    check("wrap_rst_cnt", int'(press_cnt), 0);
    sys_rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 255; i++) do_press();
    check("wrap_255", int'(press_cnt), 255);
    do_press();
    check("wrap_0", int'(press_cnt), 0);
    check("wrap_value", int'(key_value), 1);
    tick(2);

    // 5: reset in the middle of qualification
    flag_base = n_flag;
    key = 1'b0;
    tick(3);
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_value", int'(key_value), 1);
    check("mid_rst_state", int'(dut.r_state), int'(IDLE));
    tick(2);
    check("mid_rst_state_hold", int'(dut.r_state), int'(IDLE));
    check("mid_rst_no_flag", n_flag - flag_base, 0);
    check("mid_rst_cnt", int'(press_cnt), 0);
    sys_rst_n = 1'b1;
    tick(6);
    check("mid_rst_early_value", int'(key_value), 1);
    tick(1);
    check("mid_rst_value_low", int'(key_value), 0);
    check("mid_rst_flag", int'(key_flag), 1);
    check("mid_rst_cnt1", int'(press_cnt), 1);
    key = 1'b1;
    tick(8);

    // 6: long press
    long_base = n_long;
    key = 1'b0;
    tick(7);
    check("long_press_value", int'(key_value), 0);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    tick(19);
    check("long_early", n_long - long_base, 0);
    tick(1);
    check("long_flag", int'(long_flag), 1);
    tick(1);
    check("long_flag_end", int'(long_flag), 0);
    tick(12);
    check("long_once", n_long - long_base, 1);
`else
    tick(33);
    check("long_none", n_long - long_base, 0);
`endif
    key = 1'b1;
    tick(8);
    check("long_rel_value", int'(key_value), 1);
    check("long_rel_cnt", int'(press_cnt), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
